// File: rtl/multicycle_core.sv
// multicycle_core: parametrised multicycle core with req/ack instruction and data ports.
// Define MC_PERF_CNT_EN to add the cyc_cnt/instr_cnt performance counter outputs.
module multicycle_core #(
  parameter int DW   = 32,
  parameter int AW   = 16,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic [AW-1:0] pc,
  output logic [2:0]    state,
  output logic          halted
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]   cyc_cnt,
  output logic [31:0]   instr_cnt
`endif
);

  localparam int RW = $clog2(NREG);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] pc_q;
  logic [31:0]   ir_q;
  logic [DW-1:0] a_q, b_q, alu_q, mdr_q;
  logic [DW-1:0] rf [NREG];

  logic [5:0]    op;
  logic [15:0]   imm;
  logic [RW-1:0] rs_idx, rt_idx, rd_idx, wb_idx;
  logic          is_r, is_i, is_lw, is_sw;
  logic          is_beq, is_bne, is_j, is_halt, is_nop;
  logic [DW-1:0] imm_dw, opb, alu_y, rd_a, rd_b, wb_data;
  logic [AW-1:0] imm_aw;
  logic [3:0]    fn;
  logic [4:0]    shamt;
  logic          take;

  assign op     = ir_q[31:26];
  assign imm    = ir_q[15:0];
  assign rs_idx = ir_q[21 +: RW];
  assign rt_idx = ir_q[16 +: RW];
  assign rd_idx = ir_q[11 +: RW];

  assign is_r    = (op[5:4] == 2'b00);
  assign is_i    = (op[5:4] == 2'b01);
  assign is_lw   = (op == 6'b100000);
  assign is_sw   = (op == 6'b100001);
  assign is_beq  = (op == 6'b100010);
  assign is_bne  = (op == 6'b100011);
  assign is_j    = (op == 6'b100100);
  assign is_halt = (op == 6'b111111);
  assign is_nop  = !(is_r | is_i | is_lw | is_sw |
                     is_beq | is_bne | is_j | is_halt);

  assign imm_dw = DW'(signed'(imm));
  assign imm_aw = AW'(signed'(imm));

  assign rd_a = (rs_idx == '0) ? '0 : rf[rs_idx];
  assign rd_b = (rt_idx == '0) ? '0 : rf[rt_idx];

  // Loads and stores reuse the ALU adder for the address.
  assign opb   = (is_i | is_lw | is_sw) ? imm_dw : b_q;
  assign fn    = (is_r | is_i) ? op[3:0] : 4'd0;
  assign shamt = opb[4:0];

  always_comb begin
    alu_y = '0;
    case (fn)
      4'd0:    alu_y = a_q + opb;
      4'd1:    alu_y = a_q - opb;
      4'd2:    alu_y = a_q & opb;
      4'd3:    alu_y = a_q | opb;
      4'd4:    alu_y = a_q ^ opb;
      4'd5:    alu_y = DW'($signed(a_q) < $signed(opb));
      4'd6:    alu_y = a_q << shamt;
      4'd7:    alu_y = a_q >> shamt;
      default: alu_y = '0;
    endcase
  end

  assign take = (is_beq & (a_q == b_q)) |
                (is_bne & (a_q != b_q));

  assign wb_idx  = is_r ? rd_idx : rt_idx;
  assign wb_data = is_lw ? mdr_q : alu_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:
        if (imem_ack) state_d = S_DECODE;
      S_DECODE:
        unique case (1'b1)
          is_j, is_nop: state_d = S_FETCH;
          is_halt:      state_d = S_HALT;
          default:      state_d = S_EXEC;
        endcase
      S_EXEC:
        unique case (1'b1)
          is_beq, is_bne: state_d = S_FETCH;
          is_lw, is_sw:   state_d = S_MEM;
          default:        state_d = S_WB;
        endcase
      S_MEM:
        if (dmem_ack) state_d = is_lw ? S_WB : S_FETCH;
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= '0;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      unique case (state_q)
        S_FETCH:
          if (imem_ack) begin
            ir_q <= imem_rdata;
            pc_q <= pc_q + AW'(1);
          end
        S_DECODE: begin
          a_q <= rd_a;
          b_q <= rd_b;
          if (is_j) pc_q <= AW'(imm);
        end
        S_EXEC: begin
          alu_q <= alu_y;
          // pc_q already points past the branch here.
          if (take) pc_q <= pc_q + imm_aw;
        end
        S_MEM:
          if (dmem_ack && is_lw) mdr_q <= dmem_rdata;
        S_WB:
          if (wb_idx != '0) rf[wb_idx] <= wb_data;
        default: ;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      if (state_q != S_HALT) cyc_cnt <= cyc_cnt + 32'd1;
      if (state_q == S_DECODE && !is_halt)
        instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = dmem_req & is_sw;
  assign dmem_addr  = AW'(alu_q);
  assign dmem_wdata = b_q;
  assign pc         = pc_q;
  assign state      = state_q;
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed self-checking bench for multicycle_core.
// Covers ALU ops, delayed loads, branches, stores, reset abort, halt and PC wrap.
module tb_multicycle_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic [15:0] pc;
  logic [2:0]  state;
  logic        halted;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_cnt, instr_cnt;
  logic [31:0] s_cyc_cnt, s_instr_cnt;
`endif

  logic        s_imem_req, s_imem_ack;
  logic [3:0]  s_imem_addr;
  logic [31:0] s_imem_rdata;
  logic        s_dmem_req, s_dmem_we, s_dmem_ack;
  logic [3:0]  s_dmem_addr;
  logic [15:0] s_dmem_wdata, s_dmem_rdata;
  logic [3:0]  s_pc;
  logic [2:0]  s_state;
  logic        s_halted;

  always #5 clk = ~clk;

  multicycle_core dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .state(state), .halted(halted)
`ifdef MC_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
  );

  multicycle_core #(.DW(16), .AW(4), .NREG(4)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .imem_req(s_imem_req), .imem_addr(s_imem_addr),
    .imem_ack(s_imem_ack), .imem_rdata(s_imem_rdata),
    .dmem_req(s_dmem_req), .dmem_we(s_dmem_we),
    .dmem_addr(s_dmem_addr), .dmem_wdata(s_dmem_wdata),
    .dmem_ack(s_dmem_ack), .dmem_rdata(s_dmem_rdata),
    .pc(s_pc), .state(s_state), .halted(s_halted)
`ifdef MC_PERF_CNT_EN
    , .cyc_cnt(s_cyc_cnt), .instr_cnt(s_instr_cnt)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rt_op(input logic [5:0] op,
    input int rs, input int rt, input int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] it_op(input logic [5:0] op,
    input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  logic [15:0] m_addr;
  logic        m_we;
  logic [31:0] m_wdata;
  bit          m_seen, m_stable;

  // Serves one instruction from FETCH until the next FETCH (or HALT).
  task automatic run(input logic [31:0] instr, input int dly,
                     input logic [31:0] rd, output int cyc);
    int waits;
    cyc = 0;
    waits = 0;
    m_seen = 0;
    m_stable = 1;
    do begin
      imem_rdata = instr;
      imem_ack   = (state == 3'd0);
      dmem_rdata = rd;
      dmem_ack   = (state == 3'd3) && (waits >= dly);
      if (state == 3'd3) begin
        if (!m_seen) begin
          m_addr  = dmem_addr;
          m_we    = dmem_we;
          m_wdata = dmem_wdata;
          m_seen  = 1;
        end else if (dmem_addr !== m_addr || dmem_we !== m_we ||
                     dmem_wdata !== m_wdata) begin
          m_stable = 0;
        end
        if (!dmem_ack) waits++;
      end
      @(negedge clk);
      cyc++;
    end while (state != 3'd0 && state != 3'd7 && cyc < 40);
    imem_ack = 0;
    dmem_ack = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 0;
    imem_ack = 0; imem_rdata = '0;
    dmem_ack = 0; dmem_rdata = '0;
    s_imem_ack = 0; s_imem_rdata = '0;
    s_dmem_ack = 0; s_dmem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_pc", pc, 0);
    check("rst_imem_req", imem_req, 1);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_halted", halted, 0);
    rst_n = 1;
    @(negedge clk);
    check("first_fetch", imem_req, 1);

    run(it_op(6'h10, 0, 1, 5), 0, 0, c);
    check("addi_cyc", c, 4);
    run(it_op(6'h10, 0, 2, 7), 0, 0, c);
    run(rt_op(6'h00, 1, 2, 3), 0, 0, c);
    check("add_cyc", c, 4);
    check("add_pc", pc, 3);
    run(rt_op(6'h01, 1, 2, 4), 0, 0, c);
    check("sub_cyc", c, 4);
    run(it_op(6'h21, 0, 3, 0), 0, 0, c);
    check("sw_cyc", c, 4);
    check("add_r3", m_wdata, 32'd12);
    run(it_op(6'h21, 0, 4, 0), 0, 0, c);
    check("sub_r4", m_wdata, 32'hFFFF_FFFE);

    run(it_op(6'h20, 0, 5, 4), 3, 32'hDEAD_BEEF, c);
    check("lw_cyc", c, 8);
    check("lw_addr", m_addr, 4);
    check("lw_we", m_we, 0);
    check("lw_stable", m_stable, 1);
    run(it_op(6'h21, 0, 5, 0), 0, 0, c);
    check("lw_r5", m_wdata, 32'hDEAD_BEEF);

    run(it_op(6'h21, 0, 2, 3), 0, 0, c);
    check("sw_we", m_we, 1);
    check("sw_addr", m_addr, 3);
    check("sw_wdata", m_wdata, 7);
    run(it_op(6'h10, 0, 0, 9), 0, 0, c);
    check("pc10", pc, 10);

    run(it_op(6'h22, 1, 1, -1), 0, 0, c);
    check("beq_cyc", c, 3);
    check("beq_tgt", imem_addr, 10);
    run(it_op(6'h23, 1, 1, 5), 0, 0, c);
    check("bne_nt_cyc", c, 3);
    check("bne_nt_pc", pc, 11);
    run(it_op(6'h21, 0, 0, 0), 0, 0, c);
    check("r0_zero", m_wdata, 0);
    run({6'h24, 26'h20}, 0, 0, c);
    check("j_cyc", c, 2);
    check("j_tgt", imem_addr, 16'h20);
    run({6'h25, 26'h0}, 0, 0, c);
    check("nop_cyc", c, 2);
    check("nop_pc", pc, 16'h21);
    run(it_op(6'h23, 1, 2, -2), 0, 0, c);
    check("bne_t_pc", pc, 16'h20);
    run(it_op(6'h14, 1, 6, 16'hFFFF), 0, 0, c);
    run(it_op(6'h21, 0, 6, 0), 0, 0, c);
    check("xori_r6", m_wdata, 32'hFFFF_FFFA);
    run(rt_op(6'h05, 4, 1, 7), 0, 0, c);
    run(it_op(6'h21, 0, 7, 0), 0, 0, c);
    check("slt_r7", m_wdata, 1);

    imem_rdata = it_op(6'h20, 0, 5, 4);
    imem_ack = 1;
    @(negedge clk);
    imem_ack = 0;
    @(negedge clk);
    @(negedge clk);
    check("mem_wait_state", state, 3);
    check("mem_wait_req", dmem_req, 1);
    rst_n = 0;
    @(negedge clk);
    check("abort_pc", pc, 0);
    check("abort_dmem_req", dmem_req, 0);
    check("abort_state", state, 0);
    rst_n = 1;
    dmem_ack = 1;
    dmem_rdata = 32'h1234;
    @(negedge clk);
    dmem_ack = 0;
    check("late_ack_state", state, 0);
    check("late_ack_pc", pc, 0);

    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) run({6'h25, 26'h0}, 0, 0, c);
    check("nop3_pc", pc, 3);
`ifdef MC_PERF_CNT_EN
    check("perf_cyc", cyc_cnt, 6);
    check("perf_instr", instr_cnt, 3);
`endif
    run(it_op(6'h21, 0, 1, 0), 0, 0, c);
    check("rst_rf_clear", m_wdata, 0);
    run(32'hFC00_0000, 0, 0, c);
    check("halt_cyc", c, 2);
    check("halt_state", state, 7);
    check("halted", halted, 1);
    imem_ack = 1;
    dmem_ack = 1;
    repeat (3) @(negedge clk);
    imem_ack = 0;
    dmem_ack = 0;
    check("halt_hold", state, 7);
    check("halt_hold_flag", halted, 1);
    check("halt_no_req", imem_req, 0);
    check("halt_pc", pc, 5);
`ifdef MC_PERF_CNT_EN
    check("perf_cyc_halt", cyc_cnt, 12);
    check("perf_instr_halt", instr_cnt, 4);
`endif

    check("s_pc0", s_pc, 0);
    s_imem_rdata = {6'h24, 26'd15};
    s_imem_ack = 1;
    @(negedge clk);
    s_imem_ack = 0;
    check("s_decode", s_state, 1);
    @(negedge clk);
    check("s_j_pc", s_pc, 15);
    check("s_j_state", s_state, 0);
    s_imem_rdata = {6'h25, 26'd0};
    s_imem_ack = 1;
    @(negedge clk);
    s_imem_ack = 0;
    check("s_wrap_pc", s_pc, 0);
    @(negedge clk);
    check("s_wrap_state", s_state, 0);
    check("s_wrap_addr", s_imem_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
